// File: rtl/mlp_step_sequencer_if.sv
// mlp_step_sequencer_if
//
// Groups the frame/step/result signals between the MLP step sequencer and
// the stages around it (UART RX/TX, weight/bias loaders, FC layers).
//
// Signals:
//   frame_valid   RX -> seq   input buffer holds a complete frame
//   frame_ready   seq -> RX   sequencer idle, can accept a frame
//   step_start    seq -> stg  one-hot single-cycle start pulse per stage
//   step_done     stg -> seq  per-stage done (level or pulse)
//   step_idx      seq -> obs  index of current or last issued step
//   capture       seq -> regs strobe to latch inter-layer outputs
//   result_valid  seq -> TX   final layer output is stable
//   result_ready  TX -> seq   TX has taken the result
//   busy          seq -> obs  frame in progress
//   error         seq -> obs  watchdog expired (sticky until abort/rst)
//   err_step      seq -> obs  step index that timed out
//   abort         ctl -> seq  return to idle from any state
//   frame_count   seq -> obs  completed frames (wrapping)
//
// master: the sequencer.  slave: the environment around it.
interface mlp_step_sequencer_if #(
  parameter int unsigned NUM_STEPS = 9
);
  logic                 frame_valid;
  logic                 frame_ready;
  logic [NUM_STEPS-1:0] step_start;
  logic [NUM_STEPS-1:0] step_done;
  logic [3:0]           step_idx;
  logic                 capture;
  logic                 result_valid;
  logic                 result_ready;
  logic                 busy;
  logic                 error;
  logic [3:0]           err_step;
  logic                 abort;
  logic [15:0]          frame_count;

  modport master (
    input  frame_valid, step_done, result_ready, abort,
    output frame_ready, step_start, step_idx, capture, result_valid,
           busy, error, err_step, frame_count
  );

  modport slave (
    output frame_valid, step_done, result_ready, abort,
    input  frame_ready, step_start, step_idx, capture, result_valid,
           busy, error, err_step, frame_count
  );
endinterface

// File: rtl/mlp_step_sequencer.sv
// mlp_step_sequencer
//
// Frame-level scheduler for the MLP inference chain. On frame_valid it fires
// each stage in turn with a one-cycle start pulse, waits for a fresh rising
// edge of that stage's done, optionally strobes capture, and finally holds
// result_valid until the TX stage takes it. A per-step watchdog parks the
// FSM in ERROR; abort returns to IDLE from anywhere.
//
// Ports:
//   clk_100MHz  system clock (rising edge)
//   rst         synchronous active-high reset
//   bus         mlp_step_sequencer_if.master (see interface for signal list)
//
// Every output is a flop whose next value is derived from the next state, so
// no input reaches an output combinationally.
module mlp_step_sequencer #(
  parameter int unsigned          NUM_STEPS    = 9,
  parameter logic [NUM_STEPS-1:0] CAPTURE_MASK = 9'b000100000,
  parameter logic [23:0]          TIMEOUT      = 24'd10_000_000
) (
  input logic                  clk_100MHz,
  input logic                  rst,
  mlp_step_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESULT,
    S_ERROR
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           step_idx_q, step_idx_d;
  logic [NUM_STEPS-1:0] step_start_q, step_start_d;
  logic                 capture_q, capture_d;
  logic                 result_valid_q, result_valid_d;
  logic                 frame_ready_q, frame_ready_d;
  logic                 busy_q, busy_d;
  logic                 error_q, error_d;
  logic [3:0]           err_step_q, err_step_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic [NUM_STEPS-1:0] done_q, done_d;
  logic [23:0]          timer_q, timer_d;

  logic [NUM_STEPS-1:0] cur_onehot;
  logic [NUM_STEPS-1:0] done_rise;
  logic                 step_fire;
  logic                 last_step;
  logic                 cap_sel;
  logic                 expire;

  always_comb begin
    cur_onehot = NUM_STEPS'(1) << step_idx_q;
    // Only a 0->1 transition counts; a done already high on entry never fires.
    done_rise  = bus.step_done & ~done_q;
    step_fire  = |(done_rise & cur_onehot);
    last_step  = (step_idx_q == 4'(NUM_STEPS - 1));
    cap_sel    = |(CAPTURE_MASK & cur_onehot);
    expire     = (TIMEOUT != 24'd0) && (timer_q == (TIMEOUT - 24'd1));
  end

  always_comb begin
    state_d        = state_q;
    step_idx_d     = step_idx_q;
    capture_d      = 1'b0;
    result_valid_d = result_valid_q;
    error_d        = error_q;
    err_step_d     = err_step_q;
    frame_count_d  = frame_count_q;
    done_d         = bus.step_done;
    timer_d        = timer_q;
    step_start_d   = '0;
    frame_ready_d  = 1'b0;
    busy_d         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_valid) begin
          state_d    = S_ISSUE;
          step_idx_d = 4'd0;
        end
      end
      S_ISSUE: begin
        timer_d = 24'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion is checked before expiry so a done on the last timer
        // cycle still counts.
        if (step_fire) begin
          capture_d = cap_sel;
          if (last_step) begin
            state_d        = S_RESULT;
            result_valid_d = 1'b1;
            frame_count_d  = frame_count_q + 16'd1;
          end else begin
            state_d    = S_ISSUE;
            step_idx_d = step_idx_q + 4'd1;
          end
        end else if (expire) begin
          state_d    = S_ERROR;
          error_d    = 1'b1;
          err_step_d = step_idx_q;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      S_RESULT: begin
        if (bus.result_ready) begin
          state_d        = S_IDLE;
          result_valid_d = 1'b0;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    // abort overrides whatever the state logic decided this cycle; a stage
    // already running keeps going and its late done is simply ignored.
    if (bus.abort) begin
      state_d        = S_IDLE;
      capture_d      = 1'b0;
      result_valid_d = 1'b0;
      error_d        = 1'b0;
      err_step_d     = 4'd0;
      timer_d        = 24'd0;
      step_idx_d     = step_idx_q;
      frame_count_d  = frame_count_q;
    end

    if (state_d == S_ISSUE) begin
      step_start_d = NUM_STEPS'(1) << step_idx_d;
    end
    frame_ready_d = (state_d == S_IDLE);
    busy_d        = (state_d == S_ISSUE) || (state_d == S_WAIT) ||
                    (state_d == S_RESULT);
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q        <= S_IDLE;
      step_idx_q     <= 4'd0;
      step_start_q   <= '0;
      capture_q      <= 1'b0;
      result_valid_q <= 1'b0;
      frame_ready_q  <= 1'b1;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
      err_step_q     <= 4'd0;
      frame_count_q  <= 16'd0;
      done_q         <= '0;
      timer_q        <= 24'd0;
    end else begin
      state_q        <= state_d;
      step_idx_q     <= step_idx_d;
      step_start_q   <= step_start_d;
      capture_q      <= capture_d;
      result_valid_q <= result_valid_d;
      frame_ready_q  <= frame_ready_d;
      busy_q         <= busy_d;
      error_q        <= error_d;
      err_step_q     <= err_step_d;
      frame_count_q  <= frame_count_d;
      done_q         <= done_d;
      timer_q        <= timer_d;
    end
  end

  assign bus.frame_ready  = frame_ready_q;
  assign bus.step_start   = step_start_q;
  assign bus.step_idx     = step_idx_q;
  assign bus.capture      = capture_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.error        = error_q;
  assign bus.err_step     = err_step_q;
  assign bus.frame_count  = frame_count_q;

endmodule

// File: tb/tb_mlp_step_sequencer.sv
// Directed bench for mlp_step_sequencer: nominal frame, backpressure,
// level-held done with watchdog, never-done watchdog, abort racing the final
// done, reset in WAIT, and frame counter wrap. A simple stage responder
// returns done a programmable number of cycles after each start pulse.
module tb_mlp_step_sequencer;

  localparam int NS = 9;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mlp_step_sequencer_if #(.NUM_STEPS(NS)) bus ();

  mlp_step_sequencer #(
    .NUM_STEPS   (NS),
    .CAPTURE_MASK(9'b000100000),
    .TIMEOUT     (24'd20)
  ) dut (
    .clk_100MHz(clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Stage responder: dly[i]=0 means stage i never answers; hold[i] keeps
  // done high once raised.
  int unsigned dly  [NS];
  bit          hold [NS];
  int unsigned cnt  [NS];

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (rst) begin
        cnt[i]           = 0;
        bus.step_done[i] = 1'b0;
      end else begin
        if (!hold[i]) bus.step_done[i] = 1'b0;
        if (cnt[i] != 0) begin
          cnt[i] = cnt[i] - 1;
          if (cnt[i] == 0) bus.step_done[i] = 1'b1;
        end
        if (bus.step_start[i] && dly[i] != 0) cnt[i] = dly[i];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {bus.frame_ready, bus.busy, bus.result_valid, bus.capture, bus.error},
        5'b10000);
    chk({tag, "_start"}, 32'(bus.step_start), 32'd0);
    chk({tag, "_idx"}, 32'(bus.step_idx), 32'd0);
    chk({tag, "_errstep"}, 32'(bus.err_step), 32'd0);
    chk({tag, "_fcount"}, 32'(bus.frame_count), 32'd0);
  endtask

  task automatic wait_start(input int idx, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus.step_start[idx]) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("start%0d_seen", idx), 32'(seen), 32'd1);
  endtask

  // Starts counting at the ISSUE cycle of step idx; 20 WAIT cycles follow,
  // then ERROR.
  task automatic expect_timeout(input int idx);
    bit seen;
    wait_start(idx, seen);
    repeat (20) @(negedge clk);
    chk($sformatf("wd%0d_pre", idx), 32'(bus.error), 32'd0);
    @(negedge clk);
    chk($sformatf("wd%0d_err", idx), {bus.error, bus.busy, bus.frame_ready}, 3'b100);
    chk($sformatf("wd%0d_errstep", idx), 32'(bus.err_step), 32'(idx));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("wd%0d_nostart", idx), 32'(bus.step_start), 32'd0);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk($sformatf("wd%0d_abort", idx),
        {bus.error, bus.busy, bus.frame_ready, bus.result_valid}, 4'b0010);
    chk($sformatf("wd%0d_abort_errstep", idx), 32'(bus.err_step), 32'd0);
    chk($sformatf("wd%0d_abort_idx", idx), 32'(bus.step_idx), 32'(idx));
  endtask

  initial begin
    logic [NS-1:0] exp_start;
    logic [15:0]   fc_before;
    bit            seen;

    for (int i = 0; i < NS; i++) begin
      dly[i]  = 3;
      hold[i] = 1'b0;
    end
    rst              = 1'b1;
    bus.frame_valid  = 1'b0;
    bus.result_ready = 1'b0;
    bus.abort        = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Nominal frame: done 3 cycles after each start -> 4 cycles per step.
    bus.frame_valid = 1'b1;
    @(negedge clk);
    bus.frame_valid = 1'b0;
    for (int n = 1; n <= 37; n++) begin
      if (n > 1) @(negedge clk);
      exp_start = '0;
      if (((n - 1) % 4 == 0) && ((n - 1) / 4 < NS)) exp_start = NS'(1) << ((n - 1) / 4);
      chk($sformatf("nom_c%0d", n),
          {bus.frame_ready, bus.busy, bus.result_valid, bus.capture, bus.step_start},
          {1'b0, 1'b1, (n >= 37), (n == 25), exp_start});
    end

    // Backpressure: result held, new frame_valid ignored.
    bus.frame_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("bp_hold", {bus.frame_ready, bus.busy, bus.result_valid, bus.step_start},
          {3'b011, 9'd0});
    end
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    hold[2] = 1'b1;
    chk("bp_release", {bus.frame_ready, bus.result_valid}, 2'b10);
    chk("bp_fcount", 32'(bus.frame_count), 32'd1);
    @(negedge clk);
    bus.frame_valid = 1'b0;
    chk("b2b_accept", {bus.busy, bus.step_start}, {1'b1, 9'd1});

    // Frame 2 completes; stage 2 done is now held high.
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.result_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("f2_result_seen", 32'(seen), 32'd1);
    chk("f2_fcount", 32'(bus.frame_count), 32'd2);
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    bus.frame_valid  = 1'b1;
    @(negedge clk);
    bus.frame_valid = 1'b0;

    // Frame 3: held done at step 2 never rises again -> watchdog.
    expect_timeout(2);
    hold[2] = 1'b0;

    // Frame 4: stage 4 never answers.
    dly[4] = 0;
    @(negedge clk);
    bus.frame_valid = 1'b1;
    @(negedge clk);
    bus.frame_valid = 1'b0;
    expect_timeout(4);
    dly[4] = 3;

    // Frame 5: abort on the same edge as step 8's done rise.
    fc_before = bus.frame_count;
    bus.frame_valid = 1'b1;
    @(negedge clk);
    bus.frame_valid = 1'b0;
    wait_start(8, seen);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_race", {bus.busy, bus.frame_ready, bus.result_valid}, 3'b010);
    chk("abort_race_fcount", 32'(bus.frame_count), 32'(fc_before));
    repeat (3) @(negedge clk);
    chk("abort_race_later", {bus.result_valid, bus.busy}, 2'b00);

    // Reset while in WAIT.
    bus.frame_valid = 1'b1;
    @(negedge clk);
    bus.frame_valid = 1'b0;
    wait_start(1, seen);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_wait");
    rst = 1'b0;
    @(negedge clk);

    // Counter wrap with minimum latency (done one cycle after start).
    for (int i = 0; i < NS; i++) dly[i] = 1;
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    chk("wrap_preload", 32'(bus.frame_count), 32'hFFFF);
    bus.frame_valid = 1'b1;
    @(negedge clk);
    bus.frame_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("minlat_pre", 32'(bus.result_valid), 32'd0);
    @(negedge clk);
    chk("minlat_rv", 32'(bus.result_valid), 32'd1);
    chk("wrap_fcount", 32'(bus.frame_count), 32'd0);
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    chk("wrap_idle", {bus.frame_ready, bus.result_valid, bus.busy}, 3'b100);
    chk("wrap_fcount_after", 32'(bus.frame_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
